seg_display_arbiter: RTL and testbench

SEG_DISPLAY_ARBITER -- requirements
Module: seg_display_arbiter

---
 rtl/seg_display_arbiter_if.sv | 33 +++
 rtl/seg_display_arbiter.sv | 128 ++++++++++++
 tb/tb_seg_display_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/seg_display_arbiter_if.sv
// ============================================================================
// Module   : seg_display_arbiter_if
// Brief    : Request/grant and seven-segment bus for the display arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface seg_display_arbiter_if;
  logic        req_a;
  logic [15:0] val_a;
  logic        req_b;
  logic [15:0] val_b;
  logic        gnt_a;
  logic        gnt_b;
  logic [1:0]  owner;
  logic        busy;
  logic [7:0]  HEX0;
  logic [7:0]  HEX1;
  logic [7:0]  HEX2;
  logic [7:0]  HEX3;

  modport master (
    output req_a, val_a, req_b, val_b,
    input  gnt_a, gnt_b, owner, busy, HEX0, HEX1, HEX2, HEX3
  );

  modport slave (
    input  req_a, val_a, req_b, val_b,
    output gnt_a, gnt_b, owner, busy, HEX0, HEX1, HEX2, HEX3
  );
endinterface

`default_nettype wire

// File: rtl/seg_display_arbiter.sv
// ============================================================================
// Module   : seg_display_arbiter
// Brief    : Two-requester round-robin owner of a 4-digit hex display with a
//            minimum hold window per granted value.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seg_display_arbiter #(
  parameter int unsigned HOLD_CYCLES = 32'd50000000
) (
  input  logic                 clk,
  input  logic                 reset,
  seg_display_arbiter_if.slave bus
);

  localparam logic [0:0]  S_IDLE      = 1'b0;
  localparam logic [0:0]  S_HOLD      = 1'b1;
  localparam logic [1:0]  C_OWN_NONE  = 2'b00;
  localparam logic [1:0]  C_OWN_A     = 2'b01;
  localparam logic [1:0]  C_OWN_B     = 2'b10;
  localparam logic        C_LAST_A    = 1'b0;
  localparam logic        C_LAST_B    = 1'b1;
  localparam logic [31:0] C_HOLD_LAST = HOLD_CYCLES - 32'd1;

  logic [0:0]  r_state;
  logic [31:0] r_hold_cnt;
  logic        r_last;
  logic [15:0] r_disp_val;
  logic        r_disp_valid;
  logic        r_gnt_a;
  logic        r_gnt_b;
  logic [1:0]  r_owner;

  logic w_expiry;
  logic w_owner_is_a;
  logic w_owner_req;
  logic w_other_req;
  logic w_pick_other;
  logic w_pick_owner;
  logic w_grant_a;
  logic w_grant_b;
  logic w_to_idle;

  assign w_expiry     = (r_state == S_HOLD) && (r_hold_cnt == C_HOLD_LAST);
  assign w_owner_is_a = (r_owner == C_OWN_A);
  assign w_owner_req  = w_owner_is_a ? bus.req_a : bus.req_b;
  assign w_other_req  = w_owner_is_a ? bus.req_b : bus.req_a;
  // At expiry the waiting requester beats an owner re-request on the same edge.
  assign w_pick_other = w_expiry && w_other_req;
  assign w_pick_owner = !w_pick_other && w_owner_req;

  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    w_to_idle = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_a && bus.req_b) begin
          w_grant_a = (r_last == C_LAST_B);
          w_grant_b = (r_last == C_LAST_A);
        end else begin
          w_grant_a = bus.req_a;
          w_grant_b = bus.req_b;
        end
      end
      S_HOLD: begin
        w_grant_a = (w_pick_other && !w_owner_is_a) || (w_pick_owner && w_owner_is_a);
        w_grant_b = (w_pick_other && w_owner_is_a) || (w_pick_owner && !w_owner_is_a);
        w_to_idle = w_expiry && !w_other_req && !w_owner_req;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_hold_cnt   <= 32'd0;
      r_last       <= C_LAST_B;
      r_disp_val   <= 16'h0000;
      r_disp_valid <= 1'b0;
      r_gnt_a      <= 1'b0;
      r_gnt_b      <= 1'b0;
      r_owner      <= C_OWN_NONE;
    end else begin
      r_gnt_a <= w_grant_a;
      r_gnt_b <= w_grant_b;
      if (w_grant_a || w_grant_b) begin
        r_state      <= S_HOLD;
        r_hold_cnt   <= 32'd0;
        r_last       <= w_grant_a ? C_LAST_A : C_LAST_B;
        r_owner      <= w_grant_a ? C_OWN_A : C_OWN_B;
        r_disp_val   <= w_grant_a ? bus.val_a : bus.val_b;
        r_disp_valid <= 1'b1;
      end else if (w_to_idle) begin
        r_state    <= S_IDLE;
        r_owner    <= C_OWN_NONE;
        r_hold_cnt <= 32'd0;
      end else if (r_state == S_HOLD) begin
        r_hold_cnt <= r_hold_cnt + 32'd1;
      end
    end
  end

  function automatic logic [7:0] f_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'hC0;  4'h1: seg = 8'hF9;  4'h2: seg = 8'hA4;  4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;  4'h5: seg = 8'h92;  4'h6: seg = 8'h82;  4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;  4'h9: seg = 8'h90;  4'hA: seg = 8'h88;  4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;  4'hD: seg = 8'hA1;  4'hE: seg = 8'h86;  default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

  assign bus.gnt_a = r_gnt_a;
  assign bus.gnt_b = r_gnt_b;
  assign bus.owner = r_owner;
  assign bus.busy  = (r_state == S_HOLD);
  assign bus.HEX0  = r_disp_valid ? f_seg(r_disp_val[3:0])   : 8'hFF;
  assign bus.HEX1  = r_disp_valid ? f_seg(r_disp_val[7:4])   : 8'hFF;
  assign bus.HEX2  = r_disp_valid ? f_seg(r_disp_val[11:8])  : 8'hFF;
  assign bus.HEX3  = r_disp_valid ? f_seg(r_disp_val[15:12]) : 8'hFF;

endmodule

`default_nettype wire

// File: tb/tb_seg_display_arbiter.sv
// ============================================================================
// Module   : tb_seg_display_arbiter
// Brief    : Directed scenarios checked against a per-cycle arbitration model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seg_display_arbiter;
  localparam int HOLD = 4;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  int   cyc;

  seg_display_arbiter_if ifc ();

  seg_display_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  const logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                     8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Model: owner 0 none / 1 A / 2 B; age counts cycles since the last grant.
  int          m_owner = 0;
  int          m_age   = 0;
  int          m_last  = 2;
  logic [15:0] m_disp  = 16'h0;
  bit          m_valid = 1'b0;
  bit          m_ga    = 1'b0;
  bit          m_gb    = 1'b0;

  always @(posedge clk or negedge reset) begin
    int win;
    bit oreq, nreq;
    if (!reset) begin
      m_owner = 0; m_age = 0; m_last = 2; m_disp = 16'h0; m_valid = 0; m_ga = 0; m_gb = 0;
    end else begin
      win = 0;
      if (m_owner == 0) begin
        if (ifc.req_a && ifc.req_b) win = (m_last == 2) ? 1 : 2;
        else if (ifc.req_a)         win = 1;
        else if (ifc.req_b)         win = 2;
      end else begin
        oreq = (m_owner == 1) ? ifc.req_a : ifc.req_b;
        nreq = (m_owner == 1) ? ifc.req_b : ifc.req_a;
        if (m_age == HOLD - 1) begin
          if (nreq)      win = 3 - m_owner;
          else if (oreq) win = m_owner;
          else           m_owner = 0;
        end else if (oreq) win = m_owner;
        else               m_age++;
      end
      m_ga = (win == 1);
      m_gb = (win == 2);
      if (win != 0) begin
        m_owner = win; m_last = win; m_age = 0; m_valid = 1;
        m_disp  = (win == 1) ? ifc.val_a : ifc.val_b;
      end
    end
  end

  function automatic logic [31:0] model_hex();
    logic [31:0] h;
    h = 32'hFFFF_FFFF;
    if (m_valid)
      h = {seg_tab[m_disp[15:12]], seg_tab[m_disp[11:8]], seg_tab[m_disp[7:4]], seg_tab[m_disp[3:0]]};
    return h;
  endfunction

  always @(negedge clk) begin
    if (reset === 1'b1)
      check("cycle {gnt_a,gnt_b,owner,busy,HEX3..0}",
            64'({ifc.gnt_a, ifc.gnt_b, ifc.owner, ifc.busy, ifc.HEX3, ifc.HEX2, ifc.HEX1, ifc.HEX0}),
            64'({m_ga, m_gb, 2'(m_owner), (m_owner != 0), model_hex()}));
  end

  function automatic logic [31:0] hex_all();
    return {ifc.HEX3, ifc.HEX2, ifc.HEX1, ifc.HEX0};
  endfunction

  task automatic wait_gnt(input bit is_b, input string nm, output int at);
    int k;
    k = 0;
    while (((is_b ? ifc.gnt_b : ifc.gnt_a) !== 1'b1) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check(nm, 64'(is_b ? ifc.gnt_b : ifc.gnt_a), 64'd1);
    at = cyc;
  endtask

  initial begin
    int t0, t1, t2, n;
    n_cmp = 0; n_err = 0;
    reset = 1'b0;
    ifc.req_a = 1'b0; ifc.val_a = 16'h0;
    ifc.req_b = 1'b0; ifc.val_b = 16'h0;
    #1;
    check("reset HEX", 64'(hex_all()), 64'hFFFF_FFFF);
    check("reset owner/busy", 64'({ifc.owner, ifc.busy}), 64'd0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    repeat (5) @(negedge clk);
    check("idle HEX", 64'(hex_all()), 64'hFFFF_FFFF);

    // Single request from A
    ifc.req_a = 1'b1; ifc.val_a = 16'h1234;
    wait_gnt(1'b0, "gnt_a 1234", t0);
    ifc.req_a = 1'b0;
    check("HEX 1234", 64'(hex_all()), 64'hF9A4_B099);
    check("owner A", 64'(ifc.owner), 64'd1);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifc.busy) n++;
      else break;
    end
    check("busy length", 64'(n), 64'd4);
    check("HEX kept", 64'(hex_all()), 64'hF9A4_B099);

    // Tie from reset, then alternation at expiry
    @(negedge clk);
    #2 reset = 1'b0;
    ifc.req_a = 1'b1; ifc.val_a = 16'hAAAA;
    ifc.req_b = 1'b1; ifc.val_b = 16'h5555;
    @(negedge clk);
    #2 reset = 1'b1;
    wait_gnt(1'b0, "tie gnt_a", t0);
    ifc.req_a = 1'b0;
    wait_gnt(1'b1, "tie gnt_b", t1);
    ifc.req_b = 1'b0; ifc.req_a = 1'b1;
    check("B after A", 64'(t1 - t0), 64'd4);
    check("HEX 5555", 64'(hex_all()), 64'h9292_9292);
    wait_gnt(1'b0, "regnt a", t2);
    ifc.req_a = 1'b0;
    check("A after B", 64'(t2 - t1), 64'd4);
    repeat (6) @(negedge clk);

    // Owner re-request mid-hold while B waits
    ifc.req_a = 1'b1; ifc.val_a = 16'h1111;
    wait_gnt(1'b0, "gnt_a 1111", t0);
    ifc.req_a = 1'b0;
    ifc.req_b = 1'b1; ifc.val_b = 16'h2222;
    repeat (2) @(negedge clk);
    ifc.req_a = 1'b1; ifc.val_a = 16'hFFFF;
    wait_gnt(1'b0, "regrant FFFF", t1);
    ifc.req_a = 1'b0;
    check("regrant at cnt2", 64'(t1 - t0), 64'd3);
    check("HEX FFFF", 64'(hex_all()), 64'h8E8E_8E8E);
    wait_gnt(1'b1, "gnt_b after regrant", t2);
    ifc.req_b = 1'b0;
    check("B after regrant", 64'(t2 - t1), 64'd4);

    // Reset in the middle of B's window
    repeat (6) @(negedge clk);
    ifc.req_b = 1'b1; ifc.val_b = 16'hBEEF;
    wait_gnt(1'b1, "gnt_b BEEF", t0);
    ifc.req_b = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midhold reset outs", 64'({ifc.gnt_a, ifc.gnt_b, ifc.owner, ifc.busy}), 64'd0);
    check("midhold reset HEX", 64'(hex_all()), 64'hFFFF_FFFF);
    @(negedge clk);
    #2 reset = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ifc.gnt_b) n++;
    end
    check("no gnt_b after abort", 64'(n), 64'd0);

    // CDEF decode, dropped request, tie with last = A
    ifc.req_a = 1'b1; ifc.val_a = 16'hCDEF;
    wait_gnt(1'b0, "gnt_a CDEF", t0);
    ifc.req_a = 1'b0;
    check("HEX CDEF", 64'(hex_all()), 64'hC6A1_868E);
    ifc.req_b = 1'b1; ifc.val_b = 16'h7777;
    @(negedge clk);
    ifc.req_b = 1'b0;
    repeat (6) @(negedge clk);
    check("dropped req idle", 64'({ifc.owner, ifc.busy}), 64'd0);
    check("HEX CDEF kept", 64'(hex_all()), 64'hC6A1_868E);
    ifc.req_a = 1'b1; ifc.req_b = 1'b1; ifc.val_b = 16'h0789;
    wait_gnt(1'b1, "tie after A", t1);
    check("tie gnt_a low", 64'(ifc.gnt_a), 64'd0);
    ifc.req_a = 1'b0; ifc.req_b = 1'b0;
    check("HEX 0789", 64'(hex_all()), 64'hC0F8_8090);
    repeat (6) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
